pq_push_arb: RTL

- Front-end controller that shares one priority queue (sr_pq or any pq_if-compatible queue) among N push requesters and one pop consumer.
- Round-robin arbitration selects which requester's {key,val} is pushed each cycle.
- Tracks queue occupancy and gates pushes against capacity.
- Provides a drain sequence that blocks new pushes until the queue is emptied through the consumer port.

---
 rtl/pq_push_arb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pq_push_arb.sv
// Round-robin push arbiter, occupancy tracker and drain sequencer in front of a shared priority queue.
// Optional event counters and occupancy assertion are enabled with the PQ_ARB_STATS_EN macro.
module pq_push_arb #(
   parameter int N         = 4,
   parameter int CAPACITY  = 8,
   parameter int KEY_WIDTH = 8,
   parameter int VAL_WIDTH = 8,
   parameter int DW        = KEY_WIDTH + VAL_WIDTH,
   parameter int CW        = $clog2(CAPACITY + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0][DW-1:0] req_data,
   input  logic [N-1:0]         req_valid,
   output logic [N-1:0]         req_rdy,
   output logic [DW-1:0]        pq_idata,
   output logic                 pq_ivalid,
   input  logic                 pq_irdy,
   input  logic [DW-1:0]        pq_odata,
   input  logic                 pq_ovalid,
   output logic                 pq_ordy,
   output logic [DW-1:0]        cons_data,
   output logic                 cons_valid,
   input  logic                 cons_rdy,
   input  logic                 drain,
   output logic                 drain_done,
   output logic [CW-1:0]        count,
   output logic                 full,
   output logic                 empty
`ifdef PQ_ARB_STATS_EN
   ,
   output logic [31:0]          push_cnt,
   output logic [31:0]          pop_cnt
`endif
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] gnt_idx;
   logic          any_req;
   logic          push_ok;
   logic          push_fire;
   logic          pop_fire;
   logic [CW-1:0] count_nxt;

   // Requester index at a given offset from base, wrapping modulo N.
   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N) s = s - N;
      return PW'(s);
   endfunction

   assign pq_ordy    = cons_rdy;
   assign cons_data  = pq_odata;
   assign cons_valid = pq_ovalid;
   assign pop_fire   = pq_ovalid & pq_ordy;
   assign any_req    = |req_valid;

   // A pop in the same cycle frees a slot, so a full queue may still take a push.
   assign push_ok   = !rst & pq_irdy & (state == RUN) &
                      ((count < CW'(CAPACITY)) | pop_fire);
   assign pq_ivalid = push_ok & any_req;
   assign push_fire = pq_ivalid;
   assign pq_idata  = pq_ivalid ? req_data[gnt_idx] : '0;
   assign full      = (count == CW'(CAPACITY));
   assign empty     = (count == '0);

   always_comb begin
      gnt_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_valid[wrap_idx(rr_ptr, k)]) gnt_idx = wrap_idx(rr_ptr, k);
      end
   end

   always_comb begin
      req_rdy = '0;
      if (any_req) req_rdy[gnt_idx] = push_ok;
   end

   always_comb begin
      count_nxt = count;
      if (push_fire && !pop_fire)      count_nxt = count + 1'b1;
      else if (!push_fire && pop_fire) count_nxt = count - 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (drain) state_nxt = (count == '0 && !push_fire) ? DONE : DRAIN;
         end
         DRAIN: begin
            if (!drain)                          state_nxt = RUN;
            else if (count == '0 && !pop_fire)   state_nxt = DONE;
         end
         DONE: begin
            if (!drain) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         rr_ptr     <= '0;
         count      <= '0;
         drain_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         drain_done <= (state_nxt == DONE);
         if (push_fire) rr_ptr <= wrap_idx(gnt_idx, 1);
      end
   end

`ifdef PQ_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         push_cnt <= '0;
         pop_cnt  <= '0;
      end else begin
         if (push_fire) push_cnt <= push_cnt + 32'd1;
         if (pop_fire)  pop_cnt  <= pop_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (count <= CW'(CAPACITY));
         assert (!(pop_fire && !push_fire && count == '0));
      end
   end
`endif

endmodule
